ap_ctrl_perf_probe: RTL and testbench

//  Synthesizable probe upstream of the simulation dataflow monitor; taps one HLS kernel's ap_ctrl_chain

---
 rtl/perf_probe_pkg.sv | 31 +++
 rtl/perf_rec_fifo.sv | 49 ++++
 rtl/ap_ctrl_perf_probe.sv | 183 ++++++++++++++++++
 tb/tb_ap_ctrl_perf_probe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_probe_pkg.sv
// Shared types and helpers for the ap_ctrl_chain performance probe.
// PERF_PROBE_TIMESTAMP_EN adds a start-timestamp field to every record.
package perf_probe_pkg;

    localparam int REC_CNT_W = 32;
    localparam int REC_ID_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT_DONE,
        HOLD
    } state_e;

    typedef struct packed {
        logic [REC_ID_W-1:0]  id;
        logic [REC_CNT_W-1:0] latency;
        logic [REC_CNT_W-1:0] interval;
        logic [REC_CNT_W-1:0] iters;
        logic [REC_CNT_W-1:0] stalls;
`ifdef PERF_PROBE_TIMESTAMP_EN
        logic [REC_CNT_W-1:0] timestamp;
`endif
    } perf_rec_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [REC_CNT_W-1:0] sat_inc(input logic [REC_CNT_W-1:0] v);
        return (&v) ? v : v + REC_CNT_W'(1);
    endfunction

endpackage

// File: rtl/perf_rec_fifo.sv
// Synchronous record FIFO; full/empty distinguished by an extra pointer wrap bit.
// A push into a full FIFO succeeds only when a pop frees the head in the same cycle.
module perf_rec_fifo
    import perf_probe_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      clear_i,
    input  logic      push_i,
    input  perf_rec_t rec_i,
    input  logic      pop_i,
    output logic      empty_o,
    output logic      drop_o,
    output perf_rec_t head_o
);

    localparam int AW = $clog2(DEPTH);

    perf_rec_t   mem [DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic        full, do_wr, do_rd;

    assign empty_o = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_rd   = pop_i && !empty_o;
    assign do_wr   = push_i && (!full || do_rd);
    assign drop_o  = push_i && full && !do_rd;
    assign head_o  = mem[rd_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (clear_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_wr) wr_q <= wr_q + (AW+1)'(1);
            if (do_rd) rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem[wr_q[AW-1:0]] <= rec_i;
    end

endmodule

// File: rtl/ap_ctrl_perf_probe.sv
// Taps one HLS kernel's ap_ctrl_chain and pipelined-loop status; logs one perf record per transaction.
// Define PERF_PROBE_TIMESTAMP_EN for a free-running cycle counter and the rec_timestamp output.
module ap_ctrl_perf_probe
    import perf_probe_pkg::*;
#(
    parameter int CNT_W      = REC_CNT_W,
    parameter int FIFO_DEPTH = 8,
    parameter int ID_W       = REC_ID_W
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             clear,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             loop_state,
    input  logic             loop_enable,
    input  logic             loop_block,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [ID_W-1:0]  rec_id,
    output logic [CNT_W-1:0] rec_latency,
    output logic [CNT_W-1:0] rec_interval,
    output logic [CNT_W-1:0] rec_iters,
    output logic [CNT_W-1:0] rec_stalls,
`ifdef PERF_PROBE_TIMESTAMP_EN
    output logic [CNT_W-1:0] rec_timestamp,
`endif
    output logic             overflow,
    output logic             overlap,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] lat_q, int_q, it_q, st_q;
    logic [CNT_W-1:0] lat_d, int_d, it_d, st_d;
    logic [ID_W-1:0]  id_q;
    logic             overflow_q, overlap_q, busy_q;
    logic             commit, loop_act, drop, empty;
    perf_rec_t        rec_in, head;
`ifdef PERF_PROBE_TIMESTAMP_EN
    logic [CNT_W-1:0] ts_q, ts_start_q;
`endif

    assign loop_act = (state_q != IDLE) && loop_state && loop_enable;

    // *_d hold the counts including the current cycle; they become the record on commit.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        lat_d   = lat_q;
        int_d   = int_q;
        it_d    = (loop_act && !loop_block) ? sat_inc(it_q) : it_q;
        st_d    = (loop_act && loop_block) ? sat_inc(st_q) : st_q;
        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    lat_d = CNT_W'(1);
                    int_d = CNT_W'(1);
                    if (ap_ready && ap_done) commit = 1'b1;
                    else if (ap_ready)       state_d = WAIT_DONE;
                    else                     state_d = RUN;
                end
            end
            RUN: begin
                lat_d = sat_inc(lat_q);
                int_d = sat_inc(int_q);
                if (ap_ready && ap_done) commit = 1'b1;
                else if (ap_ready)       state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                lat_d = sat_inc(lat_q);
                if (ap_done) begin
                    if (ap_continue) commit = 1'b1;
                    else             state_d = HOLD;
                end
            end
            HOLD: begin
                if (ap_continue) commit = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (commit) state_d = IDLE;
    end

    always_comb begin
        rec_in          = '0;
        rec_in.id       = id_q;
        rec_in.latency  = lat_d;
        rec_in.interval = int_d;
        rec_in.iters    = it_d;
        rec_in.stalls   = st_d;
`ifdef PERF_PROBE_TIMESTAMP_EN
        rec_in.timestamp = (state_q == IDLE) ? ts_q : ts_start_q;
`endif
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            int_q      <= '0;
            it_q       <= '0;
            st_q       <= '0;
            id_q       <= '0;
            overflow_q <= 1'b0;
            overlap_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else if (clear) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            int_q      <= '0;
            it_q       <= '0;
            st_q       <= '0;
            id_q       <= '0;
            overflow_q <= 1'b0;
            overlap_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            if (commit) begin
                lat_q <= '0;
                int_q <= '0;
                it_q  <= '0;
                st_q  <= '0;
                id_q  <= id_q + ID_W'(1);
            end else begin
                lat_q <= lat_d;
                int_q <= int_d;
                it_q  <= it_d;
                st_q  <= st_d;
            end
            if (drop) overflow_q <= 1'b1;
            if (ap_start && (state_q == WAIT_DONE || state_q == HOLD)) overlap_q <= 1'b1;
        end
    end

`ifdef PERF_PROBE_TIMESTAMP_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ts_q       <= '0;
            ts_start_q <= '0;
        end else if (clear) begin
            ts_q       <= '0;
            ts_start_q <= '0;
        end else begin
            ts_q <= ts_q + CNT_W'(1);
            if (state_q == IDLE && ap_start) ts_start_q <= ts_q;
        end
    end
`endif

    perf_rec_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (ap_clk),
        .rst_ni  (ap_rst_n),
        .clear_i (clear),
        .push_i  (commit),
        .rec_i   (rec_in),
        .pop_i   (rec_ready),
        .empty_o (empty),
        .drop_o  (drop),
        .head_o  (head)
    );

    // Record fields read as zero whenever the FIFO is empty, including during reset.
    assign rec_valid    = !empty;
    assign rec_id       = rec_valid ? head.id       : '0;
    assign rec_latency  = rec_valid ? head.latency  : '0;
    assign rec_interval = rec_valid ? head.interval : '0;
    assign rec_iters    = rec_valid ? head.iters    : '0;
    assign rec_stalls   = rec_valid ? head.stalls   : '0;
`ifdef PERF_PROBE_TIMESTAMP_EN
    assign rec_timestamp = rec_valid ? head.timestamp : '0;
`endif
    assign overflow = overflow_q;
    assign overlap  = overlap_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ap_ctrl_perf_probe.sv
// Directed bench for ap_ctrl_perf_probe: transaction-level timestamp model plus literal checks.
module tb_ap_ctrl_perf_probe;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        ap_rst_n, clear, ap_start, ap_ready, ap_done, ap_continue;
    logic        loop_state, loop_enable, loop_block, rec_ready;
    logic        rec_valid, overflow, overlap, busy;
    logic [7:0]  rec_id;
    logic [31:0] rec_latency, rec_interval, rec_iters, rec_stalls;
`ifdef PERF_PROBE_TIMESTAMP_EN
    logic [31:0] rec_timestamp;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    ap_ctrl_perf_probe dut (
        .ap_clk       (clk),
        .ap_rst_n     (ap_rst_n),
        .clear        (clear),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_continue  (ap_continue),
        .loop_state   (loop_state),
        .loop_enable  (loop_enable),
        .loop_block   (loop_block),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_id       (rec_id),
        .rec_latency  (rec_latency),
        .rec_interval (rec_interval),
        .rec_iters    (rec_iters),
        .rec_stalls   (rec_stalls),
`ifdef PERF_PROBE_TIMESTAMP_EN
        .rec_timestamp(rec_timestamp),
`endif
        .overflow     (overflow),
        .overlap      (overlap),
        .busy         (busy)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Transaction model: remembers the cycle numbers of start/ready/done and derives counts from them.
    typedef struct {
        int     id;
        int     lat;
        int     intv;
        int     it;
        int     st;
        longint ts;
    } mrec_t;

    mrec_t  mq[$];
    bit     m_in, m_ovf, m_ovl;
    int     m_start, m_rdy, m_done, m_it, m_st, m_id;
    longint mcyc, m_ts;

    task automatic model_reset();
        mq.delete();
        m_in = 0; m_ovf = 0; m_ovl = 0;
        m_start = -1; m_rdy = -1; m_done = -1;
        m_it = 0; m_st = 0; m_id = 0; mcyc = 0; m_ts = 0;
    endtask

    task automatic model_commit();
        mrec_t r;
        r.id   = m_id;
        r.lat  = m_done - m_start + 1;
        r.intv = m_rdy - m_start + 1;
        r.it   = m_it;
        r.st   = m_st;
        r.ts   = m_ts;
        if (mq.size() < DEPTH) mq.push_back(r);
        else m_ovf = 1;
        m_id = (m_id + 1) % 256;
        m_in = 0;
    endtask

    task automatic model_step();
        bit cm = 0;
        if (rec_ready && mq.size() > 0) mq.delete(0);
        if (!m_in) begin
            if (ap_start) begin
                m_in = 1; m_start = int'(mcyc); m_rdy = -1; m_done = -1;
                m_it = 0; m_st = 0; m_ts = mcyc;
                if (ap_ready) begin
                    m_rdy = int'(mcyc);
                    if (ap_done) begin m_done = int'(mcyc); cm = 1; end
                end
            end
        end else begin
            if (loop_state && loop_enable) begin
                if (loop_block) m_st++;
                else            m_it++;
            end
            if (m_rdy < 0) begin
                if (ap_ready) begin
                    m_rdy = int'(mcyc);
                    if (ap_done) begin m_done = int'(mcyc); cm = 1; end
                end
            end else if (m_done < 0) begin
                if (ap_start) m_ovl = 1;
                if (ap_done) begin
                    m_done = int'(mcyc);
                    if (ap_continue) cm = 1;
                end
            end else begin
                if (ap_start) m_ovl = 1;
                if (ap_continue) cm = 1;
            end
        end
        if (cm) model_commit();
        mcyc++;
    endtask

    always @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n || clear) model_reset();
        else model_step();
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_in);
            chk("rec_valid", rec_valid, mq.size() > 0);
            chk("overflow", overflow, m_ovf);
            chk("overlap", overlap, m_ovl);
            if (mq.size() > 0 && rec_valid) begin
                chk("rec_id", rec_id, mq[0].id);
                chk("rec_latency", rec_latency, mq[0].lat);
                chk("rec_interval", rec_interval, mq[0].intv);
                chk("rec_iters", rec_iters, mq[0].it);
                chk("rec_stalls", rec_stalls, mq[0].st);
`ifdef PERF_PROBE_TIMESTAMP_EN
                chk("rec_timestamp", rec_timestamp, mq[0].ts);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
        loop_state = 0; loop_enable = 0; loop_block = 0; clear = 0;
    endtask

    task automatic one_shot();
        ap_start = 1; ap_ready = 1; ap_done = 1; ap_continue = 1;
    endtask

    int exp_ids[8] = '{1, 2, 3, 4, 5, 6, 7, 10};

    initial begin
        ap_rst_n = 0;
        rec_ready = 1;
        idle_in();
        tick(); tick();
        chk_en = 1;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", rec_valid, 0);
        chk("rst_overflow", overflow, 0);
        ap_rst_n = 1;
        tick();

        // 1: start held until ready+done at c9
        for (int c = 0; c < 10; c++) begin
            ap_start = 1; ap_ready = (c == 9); ap_done = (c == 9); ap_continue = 1;
            tick();
        end
        idle_in();
        chk("t1_valid", rec_valid, 1);
        chk("t1_id", rec_id, 0);
        chk("t1_latency", rec_latency, 10);
        chk("t1_interval", rec_interval, 10);
        tick(); tick();

        // 2: ready c2, done c7, continue c11
        for (int c = 0; c < 12; c++) begin
            ap_start = (c <= 2); ap_ready = (c == 2); ap_done = (c == 7); ap_continue = (c == 11);
            tick();
            if (c == 10) chk("t2_busy_hold", busy, 1);
        end
        idle_in();
        chk("t2_busy_c12", busy, 0);
        chk("t2_id", rec_id, 1);
        chk("t2_latency", rec_latency, 8);
        chk("t2_interval", rec_interval, 3);
        tick(); tick();

        // 3: 16 loop-enable cycles, 3 blocked
        for (int c = 0; c < 18; c++) begin
            ap_start = (c == 0);
            loop_state = (c >= 1 && c <= 16); loop_enable = (c >= 1 && c <= 16);
            loop_block = (c == 5 || c == 9 || c == 12);
            ap_ready = (c == 17); ap_done = (c == 17); ap_continue = (c == 17);
            tick();
        end
        idle_in();
        chk("t3_iters", rec_iters, 13);
        chk("t3_stalls", rec_stalls, 3);
        chk("t3_latency", rec_latency, 18);
        tick(); tick();

        // 5: single-cycle transaction; loop activity in that IDLE cycle must not count
        one_shot(); loop_state = 1; loop_enable = 1;
        tick();
        idle_in();
        chk("t5_latency", rec_latency, 1);
        chk("t5_interval", rec_interval, 1);
        chk("t5_iters", rec_iters, 0);
        tick(); tick();

        // overlap: start seen while waiting for done
        ap_start = 1; ap_ready = 1; tick();
        idle_in(); ap_start = 1; tick();
        idle_in(); ap_done = 1; ap_continue = 1; tick();
        idle_in();
        chk("ovl_flag", overlap, 1);
        chk("ovl_latency", rec_latency, 3);
        chk("ovl_interval", rec_interval, 1);
        tick();

        clear = 1; tick(); idle_in();
        chk("clr_overlap", overlap, 0);
        chk("clr_valid", rec_valid, 0);
        tick();

        // 4: ten back-to-back transactions into an 8-deep FIFO with no consumer
        rec_ready = 0;
        for (int c = 0; c < 10; c++) begin
            one_shot();
            tick();
        end
        idle_in();
        chk("t4_overflow", overflow, 1);
        chk("t4_head", rec_id, 0);
        one_shot(); rec_ready = 1; tick();
        idle_in(); rec_ready = 0;
        chk("t4_head_after_pp", rec_id, 1);
        for (int i = 0; i < 8; i++) begin
            chk("t4_drain_id", rec_id, exp_ids[i]);
            rec_ready = 1; tick(); rec_ready = 0;
        end
        chk("t4_empty", rec_valid, 0);

        // 6: asynchronous reset mid-RUN
        one_shot(); tick(); idle_in();
        ap_start = 1; tick(); ap_start = 0; tick();
        #3 ap_rst_n = 0;
        #1;
        chk("t6_valid", rec_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_id", rec_id, 0);
        @(posedge clk); #1;
        ap_rst_n = 1;
        ap_ready = 1; ap_done = 1; ap_continue = 1; tick();
        idle_in(); tick(); tick();
        chk("t6_no_record", rec_valid, 0);
        chk("t6_idle", busy, 0);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
